// File: rtl/rv523_pkg.sv
// rv523_pkg: shared widths, shift-op encodings and shifter state type
package rv523_pkg;
  localparam int XLEN = 32;
  localparam int SHAMT_W = 5;
  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b11;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} shift_state_t;
endpackage

// File: rtl/rv523_shift_step.sv
// rv523_shift_step: combinational one-bit shift selected by op; reserved op passes through
module rv523_shift_step #(
  parameter int XLEN = rv523_pkg::XLEN
) (
  input  logic [XLEN-1:0] data,
  input  logic [1:0]      op,
  output logic [XLEN-1:0] data_next
);
  import rv523_pkg::*;
  // SRA replicates the current MSB so repeated steps sign-extend
  always_comb
    data_next = op == SH_SLL ? {data[XLEN-2:0], 1'b0} :
                op == SH_SRL ? {1'b0, data[XLEN-1:1]} :
                op == SH_SRA ? {data[XLEN-1], data[XLEN-1:1]} : data;
endmodule

// File: rtl/rv523_serial_shifter.sv
// rv523_serial_shifter: multi-cycle SLL/SRL/SRA, one bit per clock, valid/ready on both sides
module rv523_serial_shifter #(
  parameter int XLEN = rv523_pkg::XLEN,
  parameter int SHAMT_W = rv523_pkg::SHAMT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_op,
  input  logic [XLEN-1:0]    in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_data
);
  import rv523_pkg::*;
  shift_state_t state, state_next;
  logic [XLEN-1:0] sreg, sreg_step;
  logic [SHAMT_W-1:0] count;
  logic [1:0] op;
  rv523_shift_step #(.XLEN(XLEN)) u_step (
    .data(sreg),
    .op(op),
    .data_next(sreg_step)
  );
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_next;
  // next state: zero shift skips straight to DONE; DONE waits for writeback
  always_comb
    state_next = state == IDLE  ? (in_valid ? (in_shamt != '0 ? SHIFT : DONE) : IDLE) :
                 state == SHIFT ? (count == SHAMT_W'(1) ? DONE : SHIFT) :
                 out_ready ? IDLE : DONE;
  // operand capture in IDLE, one shift step and count-down per SHIFT cycle
  always_ff @(posedge clk)
    if (rst) begin
      sreg <= '0;
      count <= '0;
      op <= '0;
    end else if (state == IDLE && in_valid) begin
      sreg <= in_data;
      count <= in_shamt;
      op <= in_op;
    end else if (state == SHIFT) begin
      sreg <= sreg_step;
      count <= count - SHAMT_W'(1);
    end
  // handshake outputs are pure state decodes; data comes straight from the register
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
    out_data = sreg;
  end
endmodule

// File: tb/tb_rv523_serial_shifter.sv
// tb_rv523_serial_shifter: scoreboard bench for the serial shifter
module tb_rv523_serial_shifter;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid;
  logic [1:0] in_op = 0;
  logic [31:0] in_data = 0, out_data;
  logic [4:0] in_shamt = 0;
  int checks = 0, fails = 0, cyc = 0, last_deliver = 0;
  bit prev_valid = 0;
  typedef struct {logic [31:0] data; int shamt; int acc;} exp_t;
  exp_t sb[$];
  exp_t cur;
  rv523_serial_shifter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_data(in_data), .in_shamt(in_shamt), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // result monitor: pops expected value and latency on each new out_valid, checks hold stability
  always @(negedge clk) if (!rst) begin
    checks++;
    if (out_valid && in_ready) begin fails++; $display("FAIL ready_in_done: in_ready=%b required 0", in_ready); end
    if (out_valid && !prev_valid) begin
      if (sb.size() == 0) begin checks++; fails++; $display("FAIL unexpected_result: got %h required none", out_data); end
      else begin
        cur = sb.pop_front();
        checks++;
        if (out_data !== cur.data) begin fails++; $display("FAIL result_data: got %h required %h", out_data, cur.data); end
        checks++;
        if (cyc - cur.acc != cur.shamt) begin fails++; $display("FAIL latency: got %0d required %0d", cyc - cur.acc + 1, cur.shamt + 1); end
      end
    end else if (out_valid) begin
      checks++;
      if (out_data !== cur.data) begin fails++; $display("FAIL hold_data: got %h required %h", out_data, cur.data); end
    end
    if (out_valid && out_ready) last_deliver = cyc + 1;
    prev_valid = out_valid;
  end
  task automatic send(input logic [1:0] op, input logic [31:0] d, input int sh, input logic [31:0] e, output int acc);
    bit done = 0;
    acc = 0;
    in_valid = 1; in_op = op; in_data = d; in_shamt = 5'(sh);
    for (int i = 0; i < 200 && !done; i++) begin
      if (in_ready) begin acc = cyc + 1; sb.push_back('{e, sh, cyc + 1}); done = 1; end
      @(negedge clk);
    end
    checks++;
    if (!done) begin fails++; $display("FAIL accept_timeout: in_ready=%b required 1", in_ready); end
  endtask
  task automatic wait_valid();
    for (int i = 0; i < 200 && !out_valid; i++) @(negedge clk);
    checks++;
    if (!out_valid) begin fails++; $display("FAIL valid_timeout: out_valid=%b required 1", out_valid); end
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 200 && !(sb.size() == 0 && in_ready); i++) @(negedge clk);
    checks++;
    if (sb.size() != 0 || !in_ready) begin fails++; $display("FAIL idle_timeout: pending=%0d required 0", sb.size()); end
  endtask
  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_data} !== {1'b1, 1'b0, 32'h0}) begin
      fails++; $display("FAIL reset_state: got %b%b %h required 10 00000000", in_ready, out_valid, out_data);
    end
    rst = 0;
  endtask
  task automatic test_reset_mid_op();
    int a;
    out_ready = 1;
    send(2'b01, 32'hFFFF_0000, 20, 32'h0000_0FFF, a);
    in_valid = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    sb.delete();
    rst = 0;
    checks++;
    if ({in_ready, out_valid, out_data} !== {1'b1, 1'b0, 32'h0}) begin
      fails++; $display("FAIL reset_mid_op: got %b%b %h required 10 00000000", in_ready, out_valid, out_data);
    end
    send(2'b01, 32'h8000_0000, 3, 32'h1000_0000, a);
    in_valid = 0;
    wait_idle();
  endtask
  task automatic test_sll();
    int a;
    out_ready = 1;
    send(2'b00, 32'h0000_0001, 4, 32'h0000_0010, a);
    in_valid = 0;
    wait_valid();
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin fails++; $display("FAIL sll_return_idle: got %b%b required 10", in_ready, out_valid); end
    wait_idle();
  endtask
  task automatic test_sra_srl();
    int a;
    out_ready = 1;
    send(2'b11, 32'h8000_00F0, 31, 32'hFFFF_FFFF, a);
    in_valid = 0;
    wait_idle();
    send(2'b01, 32'h8000_00F0, 31, 32'h0000_0001, a);
    in_valid = 0;
    wait_idle();
  endtask
  task automatic test_zero_and_reserved();
    int a;
    out_ready = 1;
    send(2'b00, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, a);
    in_valid = 0;
    wait_idle();
    send(2'b10, 32'hDEAD_BEEF, 7, 32'hDEAD_BEEF, a);
    in_valid = 0;
    wait_idle();
  endtask
  task automatic test_backpressure();
    int a;
    out_ready = 0;
    send(2'b01, 32'hF000_0000, 8, 32'h00F0_0000, a);
    in_valid = 0;
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0]; in_op = 2'b00; in_data = $urandom; in_shamt = 5'($urandom);
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, out_data} !== {1'b0, 1'b1, 32'h00F0_0000}) begin
        fails++; $display("FAIL backpressure_hold: got %b%b %h required 01 00f00000", in_ready, out_valid, out_data);
      end
    end
    in_valid = 0;
    out_ready = 1;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin fails++; $display("FAIL backpressure_release: got %b%b required 10", in_ready, out_valid); end
  endtask
  task automatic test_back_to_back();
    int a1, a2, a3;
    out_ready = 1;
    send(2'b00, 32'h0000_0001, 1, 32'h0000_0002, a1);
    send(2'b01, 32'h0000_0100, 2, 32'h0000_0040, a2);
    send(2'b11, 32'h8000_0000, 3, 32'hF000_0000, a3);
    in_valid = 0;
    wait_idle();
    checks++;
    if (a2 - a1 != 3 || a3 - a1 != 7) begin fails++; $display("FAIL b2b_accept_spacing: got %0d,%0d required 3,7", a2 - a1, a3 - a1); end
    checks++;
    if (last_deliver - a1 + 1 != 12) begin fails++; $display("FAIL b2b_total_cycles: got %0d required 12", last_deliver - a1 + 1); end
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_reset_mid_op();
    test_sll();
    test_sra_srl();
    test_zero_and_reserved();
    test_backpressure();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/rv523_serial_shifter.md
Name: rv523_serial_shifter

Overview:
- Multi-cycle shift unit for the RV523 integer datapath. Performs RV32I SLL/SRL/SRA one bit position per clock, so no barrel-shifter array is needed.
- Sits downstream of operand select, in parallel with the ALU, and hands its result to writeback.
- Uses valid/ready handshakes on both sides and holds its result until writeback accepts it.

Parameters:
- XLEN, 32, operand/result width in bits
- SHAMT_W, 5, shift-amount width; must equal clog2(XLEN)

Ports:
- clk  input  1  single system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand bundle valid
- in_ready  output  1  unit can accept an operand bundle
- in_op  input  2  00=SLL, 01=SRL, 11=SRA, 10=reserved (pass-through)
- in_data  input  XLEN  value to shift
- in_shamt  input  SHAMT_W  shift amount, unsigned
- out_valid  output  1  result valid
- out_ready  input  1  writeback accepts result
- out_data  output  XLEN  shifted result

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset: on any cycle where rst=1 at the clock edge:
  - state<=IDLE; shift register, count and op register <=0
  - outputs after the edge: in_ready=1, out_valid=0, out_data=0
  - rst overrides every other input, including mid-SHIFT or mid-DONE; an in-flight op is discarded silently.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1, out_valid=0
  - On in_valid=1: capture in_data to the shift register, in_shamt to count, in_op to the op register.
  - Next state is SHIFT if in_shamt!=0, else DONE.
- SHIFT:
  - in_ready=0. Each cycle, shift the register by one bit and decrement count.
  - SLL: shift left, fill 0. SRL: shift right, fill 0. SRA: shift right, fill with the current MSB. Reserved op: register unchanged, count still decrements.
  - When count==1 at the edge, the final shift happens and the next state is DONE.
- DONE:
  - out_valid=1, out_data=shift register, in_ready=0.
  - Hold out_data stable while out_ready=0, with no limit on stall length.
  - On out_ready=1, go to IDLE next cycle.
- Latency: accept edge to out_valid is in_shamt+1 cycles. shamt=0 gives 1 cycle; shamt=31 gives 32 cycles.
- Throughput: one op per in_shamt+2 cycles minimum. No overlap of accept and deliver; in_ready is low in DONE even when out_ready=1.
- Width rule: shamt uses the full SHAMT_W bits with no masking. The caller supplies bits [4:0] of rs2/imm.
- Input hygiene: in_valid is ignored outside IDLE, and in_* values are don't-care when not captured.
- out_data is registered (no combinational path from inputs). out_valid is a pure state decode.
- out_data outside DONE: holds the last shift-register value. Only out_valid qualifies it; the bench must not check out_data when out_valid=0.

Decomposition:
- Shared package rv523_pkg:
  - XLEN and SHAMT_W constants
  - shift-op encoding constants SH_SLL=2'b00, SH_SRL=2'b01, SH_SRA=2'b11
  - state enum shift_state_t {IDLE, SHIFT, DONE}
- One natural sub-module: rv523_shift_step, a combinational single-bit shift of XLEN bits selected by op. It is instantiated once inside the register feedback path and reused later by a serial multiplier.
- Control FSM and count stay in the top module.

Test Plan:
- Reset mid-op: start SRL with shamt=20, assert rst for 1 cycle at cycle 5 -> next cycle in_ready=1, out_valid=0, out_data=0; a new op then completes correctly.
- SLL: in_data=32'h0000_0001, shamt=4, out_ready=1 -> out_valid rises exactly 5 cycles after accept with out_data=32'h0000_0010; in_ready returns 1 one cycle later.
- SRA sign fill: in_data=32'h8000_00F0, shamt=31 -> out_data=32'hFFFF_FFFF after 32 cycles. Same input with SRL -> 32'h0000_0001.
- shamt=0 and reserved op: in_data=32'hDEAD_BEEF, shamt=0, op=SLL -> out_data=32'hDEAD_BEEF after 1 cycle. op=2'b10, shamt=7 -> out_data=32'hDEAD_BEEF after 8 cycles.
- Backpressure: SRL in_data=32'hF000_0000 shamt=8, out_ready=0 for 10 cycles -> out_valid=1 and out_data=32'h00F0_0000 held stable, in_ready=0 throughout, in_valid pulses ignored. Raise out_ready -> IDLE next cycle.
- Back-to-back: in_valid held high with 3 queued ops (shamt 1,2,3) and out_ready=1 -> each accepted only when in_ready=1. Results in order; total cycles = 3+4+5 = 12.
